fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end. Owns the program counter and drives the F-side inputs of the fetch/decode pipeline register: InstrFD, PCF_curr and PCPlus4FD.
- Issues one word-aligned request at a time to instruction memory over a valid/ready request channel and a valid-only response channel.
- Holds the fetched instruction under StallF and redirects on a taken branch or jump resolved in Execute (PCSrcE/PCTargetE).

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- NOP_INSTR, 32'h0000_0013, value driven on InstrFD whenever no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- StallF  in  1  hold the current fetch output; do not advance.
- PCSrcE  in  1  redirect request from Execute.
- PCTargetE  in  32  redirect target; bits [1:0] ignored and treated as 0.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid, one cycle per accepted request.
- imem_rsp_data  in  32  instruction word.
- InstrFD  out  32  instruction to the FD register.
- PCF_curr  out  32  PC of InstrFD.
- PCPlus4FD  out  32  PCF_curr + 4, modulo 2^32.
- FetchValidF  out  1  InstrFD/PCF_curr hold a real instruction.

Behaviour:
- All outputs are registered.
- Reset values:
  - state=IDLE, PCF=RESET_PC, drop=0, buffer invalid.
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - InstrFD=NOP_INSTR, PCF_curr=0, PCPlus4FD=4, FetchValidF=0.
- Reset has priority over every other input in the same cycle.
- Reset in the middle of an operation (any state) aborts the outstanding request. Any imem_rsp_valid while in IDLE is ignored.
- States: IDLE, REQ, WAIT, VALID.
- IDLE: unconditionally go to REQ on the next cycle. PCSrcE is ignored in IDLE.
- REQ:
  - imem_req_valid=1, imem_req_addr=PCF.
  - On valid&&ready, go to WAIT.
  - imem_req_addr stays stable while valid&&!ready, except on a redirect.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid with drop=0: capture Instr=imem_rsp_data and PCbuf=PCF, set PCF<=PCF+4, go to VALID.
  - On imem_rsp_valid with drop=1: discard the data, clear drop, go to REQ (PCF already holds the redirect target).
- VALID:
  - Drive FetchValidF=1, InstrFD=Instr, PCF_curr=PCbuf, PCPlus4FD=PCbuf+4.
  - If StallF=0, the instruction is consumed at this clock edge. Next cycle: FetchValidF=0, InstrFD=NOP_INSTR, state=REQ.
  - If StallF=1, stay in VALID and keep all outputs unchanged for as many cycles as StallF is asserted.
- Redirect (PCSrcE=1, any state except IDLE) takes priority over StallF and over normal transitions:
  - PCF<=PCTargetE&~3, buffer invalidated, FetchValidF<=0, InstrFD<=NOP_INSTR.
  - In REQ without a handshake: stay in REQ. imem_req_addr changes to the target on the next cycle; this protocol explicitly allows an address change on redirect.
  - In REQ with a handshake in the same cycle: go to WAIT with drop=1.
  - In WAIT with no response that cycle: drop=1, stay in WAIT.
  - In WAIT with a response in the same cycle: discard the response, go to REQ with drop=0.
  - In VALID: go to REQ.
- Wrap-around: PCF+4 at 32'hFFFF_FFFC gives 32'h0000_0000; no trap is raised.
- At most one request outstanding. Steady-state throughput is one instruction per 3 cycles with a zero-wait-state memory (REQ → WAIT → VALID).

Test Plan:
- Reset, then ready=1 and response one cycle after accept, data 32'h00500093 → first req_addr=0; FetchValidF=1 with InstrFD=32'h00500093, PCF_curr=0, PCPlus4FD=4. Next request address is 4.
- imem_req_ready held 0 for 5 cycles in REQ → req_valid=1 and req_addr constant at 0 for all 5 cycles; handshake on cycle 6.
- StallF=1 for 4 cycles while in VALID with PCF_curr=8 → outputs unchanged for all 4 cycles; next req_addr=12 only after StallF drops.
- PCSrcE=1 with PCTargetE=32'h0000_0102 while in WAIT (request for addr 4 outstanding) → the response for addr 4 is discarded and FetchValidF stays 0; next req_addr=32'h0000_0100.
- PCSrcE=1 in the same cycle as StallF=1 in VALID → redirect wins: FetchValidF=0 and InstrFD=32'h00000013 next cycle, followed by a request to the target.
- RESET_PC=32'hFFFF_FFFC → first fetch has PCF_curr=32'hFFFF_FFFC and PCPlus4FD=0; second req_addr=0. Assert rst in WAIT, then return a response → response ignored; outputs return to their reset values.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end, one outstanding imem request, redirect and stall handling
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] InstrFD,
  output logic [31:0] PCF_curr,
  output logic [31:0] PCPlus4FD,
  output logic        FetchValidF
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [31:0] r_pcf;
  logic [31:0] w_pcf_nx;
  logic        r_drop;
  logic        w_drop_nx;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nx;
  logic [31:0] r_pcbuf;
  logic [31:0] w_pcbuf_nx;
  logic        w_hs;
  logic [31:0] w_target;

  assign w_hs     = (r_state == S_REQ) && imem_req_ready;
  assign w_target = PCTargetE & ~32'h0000_0003;

  always_comb begin
    w_state_nx = r_state;
    w_pcf_nx   = r_pcf;
    w_drop_nx  = r_drop;
    w_instr_nx = r_instr;
    w_pcbuf_nx = r_pcbuf;
    case (r_state)
      S_IDLE: begin
        w_state_nx = S_REQ;
      end
      S_REQ: begin
        if (PCSrcE) begin
          w_pcf_nx = w_target;
          if (w_hs) begin
            w_state_nx = S_WAIT;
            w_drop_nx  = 1'b1;
          end
        end else if (w_hs) begin
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        // A redirect either poisons the in-flight response or swallows the one arriving now.
        if (PCSrcE) begin
          w_pcf_nx = w_target;
          if (imem_rsp_valid) begin
            w_state_nx = S_REQ;
            w_drop_nx  = 1'b0;
          end else begin
            w_drop_nx  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (r_drop) begin
            w_drop_nx  = 1'b0;
            w_state_nx = S_REQ;
          end else begin
            w_instr_nx = imem_rsp_data;
            w_pcbuf_nx = r_pcf;
            w_pcf_nx   = r_pcf + 32'd4;
            w_state_nx = S_VALID;
          end
        end
      end
      S_VALID: begin
        if (PCSrcE) begin
          w_pcf_nx   = w_target;
          w_state_nx = S_REQ;
        end else if (!StallF) begin
          w_state_nx = S_REQ;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_pcf          <= RESET_PC;
      r_drop         <= 1'b0;
      r_instr        <= NOP_INSTR;
      r_pcbuf        <= 32'd0;
      imem_req_valid <= 1'b0;
      imem_req_addr  <= RESET_PC;
      InstrFD        <= NOP_INSTR;
      PCF_curr       <= 32'd0;
      PCPlus4FD      <= 32'd4;
      FetchValidF    <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_pcf          <= w_pcf_nx;
      r_drop         <= w_drop_nx;
      r_instr        <= w_instr_nx;
      r_pcbuf        <= w_pcbuf_nx;
      imem_req_valid <= (w_state_nx == S_REQ);
      if (w_state_nx == S_REQ) begin
        imem_req_addr <= w_pcf_nx;
      end
      FetchValidF    <= (w_state_nx == S_VALID);
      InstrFD        <= (w_state_nx == S_VALID) ? w_instr_nx : NOP_INSTR;
      if (w_state_nx == S_VALID) begin
        PCF_curr  <= w_pcbuf_nx;
        PCPlus4FD <= w_pcbuf_nx + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with RESET_PC=0 and RESET_PC=FFFF_FFFC instances
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } fetch_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        mem_clr;
  logic        rst0, stall0, pcsrc0, ready0, slow0, rsp_v0, p0, req_v0, fv0;
  logic [31:0] target0, rsp_d0, pa0, req_a0, instr0, pcc0, pcp0;
  logic        rst1, stall1, pcsrc1, ready1, slow1, rsp_v1, p1, req_v1, fv1;
  logic [31:0] target1, rsp_d1, pa1, req_a1, instr1, pcc1, pcp1;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] q_req0[$];
  logic [31:0] q_req1[$];
  fetch_t      q_f0[$];
  fetch_t      q_f1[$];
  logic        fprev0, fprev1;

  fetch_unit u0 (
    .clk(clk), .rst(rst0), .StallF(stall0), .PCSrcE(pcsrc0), .PCTargetE(target0),
    .imem_req_valid(req_v0), .imem_req_ready(ready0), .imem_req_addr(req_a0),
    .imem_rsp_valid(rsp_v0), .imem_rsp_data(rsp_d0),
    .InstrFD(instr0), .PCF_curr(pcc0), .PCPlus4FD(pcp0), .FetchValidF(fv0)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk(clk), .rst(rst1), .StallF(stall1), .PCSrcE(pcsrc1), .PCTargetE(target1),
    .imem_req_valid(req_v1), .imem_req_ready(ready1), .imem_req_addr(req_a1),
    .imem_rsp_valid(rsp_v1), .imem_rsp_data(rsp_d1),
    .InstrFD(instr1), .PCF_curr(pcc1), .PCPlus4FD(pcp1), .FetchValidF(fv1)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ (a << 7);
  endfunction

  // Memory answers one cycle after accept, or two cycles when slowN is set.
  always @(posedge clk) begin
    if (mem_clr) begin
      p0 <= 1'b0; pa0 <= '0; rsp_v0 <= 1'b0; rsp_d0 <= '0;
      p1 <= 1'b0; pa1 <= '0; rsp_v1 <= 1'b0; rsp_d1 <= '0;
    end else begin
      p0     <= req_v0 && ready0;
      pa0    <= req_a0;
      rsp_v0 <= slow0 ? p0 : (req_v0 && ready0);
      rsp_d0 <= slow0 ? mem_word(pa0) : mem_word(req_a0);
      p1     <= req_v1 && ready1;
      pa1    <= req_a1;
      rsp_v1 <= slow1 ? p1 : (req_v1 && ready1);
      rsp_d1 <= slow1 ? mem_word(pa1) : mem_word(req_a1);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic fail_empty(input string nm, input logic [31:0] act);
    n_chk++;
    $display("FAIL %s: got %h expected nothing", nm, act);
  endtask

  task automatic wait_fv(input int u, input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!(u == 0 ? fv0 : fv1) && n < 50);
    chk(nm, {31'd0, (u == 0 ? fv0 : fv1)}, 32'd1);
  endtask

  task automatic wait_hs(input int u, input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(u == 0 ? (req_v0 && ready0) : (req_v1 && ready1)) && n < 50);
    chk(nm, {31'd0, (u == 0 ? (req_v0 && ready0) : (req_v1 && ready1))}, 32'd1);
  endtask

  initial begin : mon0
    fetch_t e;
    fprev0 = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (req_v0 === 1'b1 && ready0 === 1'b1) begin
        if (q_req0.size() == 0) fail_empty("u0 unexpected request", req_a0);
        else chk("u0 req_addr", req_a0, q_req0.pop_front());
      end
      if (fv0 === 1'b1 && !fprev0) begin
        if (q_f0.size() == 0) fail_empty("u0 unexpected fetch", pcc0);
        else begin
          e = q_f0.pop_front();
          chk("u0 InstrFD", instr0, e.instr);
          chk("u0 PCF_curr", pcc0, e.pc);
          chk("u0 PCPlus4FD", pcp0, e.pc4);
        end
      end
      fprev0 = (fv0 === 1'b1);
    end
  end

  initial begin : mon1
    fetch_t e;
    fprev1 = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (req_v1 === 1'b1 && ready1 === 1'b1) begin
        if (q_req1.size() == 0) fail_empty("u1 unexpected request", req_a1);
        else chk("u1 req_addr", req_a1, q_req1.pop_front());
      end
      if (fv1 === 1'b1 && !fprev1) begin
        if (q_f1.size() == 0) fail_empty("u1 unexpected fetch", pcc1);
        else begin
          e = q_f1.pop_front();
          chk("u1 InstrFD", instr1, e.instr);
          chk("u1 PCF_curr", pcc1, e.pc);
          chk("u1 PCPlus4FD", pcp1, e.pc4);
        end
      end
      fprev1 = (fv1 === 1'b1);
    end
  end

  initial begin
    mem_clr = 1'b1;
    rst0 = 1'b1; stall0 = 1'b0; pcsrc0 = 1'b0; target0 = '0; ready0 = 1'b0; slow0 = 1'b0;
    rst1 = 1'b1; stall1 = 1'b0; pcsrc1 = 1'b0; target1 = '0; ready1 = 1'b0; slow1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("u0 reset req_valid", {31'd0, req_v0}, 32'd0);
    chk("u0 reset req_addr", req_a0, 32'h0000_0000);
    chk("u0 reset InstrFD", instr0, NOP);
    chk("u0 reset PCF_curr", pcc0, 32'd0);
    chk("u0 reset PCPlus4FD", pcp0, 32'd4);
    chk("u0 reset FetchValidF", {31'd0, fv0}, 32'd0);
    chk("u1 reset req_addr", req_a1, 32'hFFFF_FFFC);

    q_req0.push_back(32'h0000_0000);
    q_req0.push_back(32'h0000_0004);
    q_req0.push_back(32'h0000_0100);
    q_req0.push_back(32'h0000_0008);
    q_req0.push_back(32'h0000_000C);
    q_f0.push_back('{32'h0050_0093, 32'h0000_0000, 32'h0000_0004});
    q_f0.push_back('{32'h0050_8093, 32'h0000_0100, 32'h0000_0104});
    q_f0.push_back('{32'h0050_0493, 32'h0000_0008, 32'h0000_000C});
    q_f0.push_back('{32'h0050_0693, 32'h0000_000C, 32'h0000_0010});

    #1 rst0 = 1'b0; mem_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("u0 req_valid held while not ready", {31'd0, req_v0}, 32'd1);
      chk("u0 req_addr stable while not ready", req_a0, 32'h0000_0000);
    end
    #1 ready0 = 1'b1;
    wait_fv(0, "u0 fetch at 0 arrives");
    #1 slow0 = 1'b1;

    wait_hs(0, "u0 accept at 4");
    @(negedge clk);
    #1 pcsrc0 = 1'b1; target0 = 32'h0000_0102;
    @(negedge clk);
    chk("u0 no fetch after redirect in WAIT", {31'd0, fv0}, 32'd0);
    #1 pcsrc0 = 1'b0;
    @(negedge clk);
    chk("u0 dropped response gives no fetch", {31'd0, fv0}, 32'd0);
    chk("u0 request after drop", {31'd0, req_v0}, 32'd1);
    chk("u0 redirect addr aligned", req_a0, 32'h0000_0100);
    #1 slow0 = 1'b0;

    wait_fv(0, "u0 fetch at 0x100 arrives");
    #1 stall0 = 1'b1; pcsrc0 = 1'b1; target0 = 32'h0000_0008;
    @(negedge clk);
    chk("u0 redirect beats stall FetchValidF", {31'd0, fv0}, 32'd0);
    chk("u0 redirect beats stall InstrFD", instr0, NOP);
    chk("u0 redirect beats stall req_valid", {31'd0, req_v0}, 32'd1);
    chk("u0 redirect beats stall req_addr", req_a0, 32'h0000_0008);
    #1 stall0 = 1'b0; pcsrc0 = 1'b0;

    wait_fv(0, "u0 fetch at 8 arrives");
    #1 stall0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("u0 stall FetchValidF", {31'd0, fv0}, 32'd1);
      chk("u0 stall InstrFD", instr0, 32'h0050_0493);
      chk("u0 stall PCF_curr", pcc0, 32'h0000_0008);
      chk("u0 stall PCPlus4FD", pcp0, 32'h0000_000C);
      chk("u0 stall no request", {31'd0, req_v0}, 32'd0);
    end
    #1 stall0 = 1'b0;
    @(negedge clk);
    chk("u0 request after stall", {31'd0, req_v0}, 32'd1);
    chk("u0 addr after stall", req_a0, 32'h0000_000C);
    wait_fv(0, "u0 fetch at 12 arrives");
    #1 ready0 = 1'b0;

    q_req1.push_back(32'hFFFF_FFFC);
    q_req1.push_back(32'h0000_0000);
    q_req1.push_back(32'hFFFF_FFFC);
    q_f1.push_back('{32'hFFAF_FE93, 32'hFFFF_FFFC, 32'h0000_0000});
    q_f1.push_back('{32'hFFAF_FE93, 32'hFFFF_FFFC, 32'h0000_0000});
    rst1 = 1'b0; ready1 = 1'b1;
    wait_fv(1, "u1 fetch at FFFFFFFC arrives");
    #1 slow1 = 1'b1;
    wait_hs(1, "u1 accept at wrapped 0");
    @(negedge clk);
    #1 rst1 = 1'b1;
    @(negedge clk);
    chk("u1 mid-reset req_valid", {31'd0, req_v1}, 32'd0);
    chk("u1 mid-reset req_addr", req_a1, 32'hFFFF_FFFC);
    chk("u1 mid-reset InstrFD", instr1, NOP);
    chk("u1 mid-reset PCF_curr", pcc1, 32'd0);
    chk("u1 mid-reset PCPlus4FD", pcp1, 32'd4);
    chk("u1 mid-reset FetchValidF", {31'd0, fv1}, 32'd0);
    #1 rst1 = 1'b0;
    @(negedge clk);
    chk("u1 stale response ignored", {31'd0, fv1}, 32'd0);
    chk("u1 restart req_valid", {31'd0, req_v1}, 32'd1);
    chk("u1 restart req_addr", req_a1, 32'hFFFF_FFFC);
    wait_fv(1, "u1 refetch after reset");
    #1 ready1 = 1'b0;

    repeat (4) @(negedge clk);
    chk("u0 request queue drained", q_req0.size(), 32'd0);
    chk("u0 fetch queue drained", q_f0.size(), 32'd0);
    chk("u1 request queue drained", q_req1.size(), 32'd0);
    chk("u1 fetch queue drained", q_f1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
